// File: rtl/t04_screen_power_ctrl_if.sv
// Command channel from the screen power controller to the LCD command sequencer.
// The master offers cmd_code with cmd_valid; the slave accepts with cmd_ready.
interface t04_screen_power_ctrl_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_code;

  modport master (output cmd_valid, output cmd_code, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_code, output cmd_ready);
endinterface

// File: rtl/t04_screen_power_ctrl.sv
// Idle scheduler: steps the LCD through ACTIVE/DIM/SLEEP, issuing one command per transition.
// Decisions land one edge after the deciding cycle; commands hold stable while cmd_ready is low.
module t04_screen_power_ctrl #(
  parameter int            CT_W     = 23,
  parameter logic [CT_W-1:0] DIM_CT   = 23'd4_000_000,
  parameter logic [CT_W-1:0] SLEEP_CT = 23'h7FFFFF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   key_edge,
  input  logic                   force_sleep,
  t04_screen_power_ctrl_if.master cmd,
  output logic [1:0]             state,
  output logic                   asleep,
  output logic [CT_W-1:0]        idle_ct
);

  typedef enum logic [1:0] {
    ST_ACTIVE = 2'd0,
    ST_DIM    = 2'd1,
    ST_SLEEP  = 2'd2,
    ST_CMD    = 2'd3
  } state_e;

  localparam logic [1:0] CODE_WAKE   = 2'b00;
  localparam logic [1:0] CODE_DIM    = 2'b01;
  localparam logic [1:0] CODE_SLEEP  = 2'b10;
  localparam logic [1:0] CODE_BRIGHT = 2'b11;

  state_e          state_q, state_d;
  state_e          target_q, target_d;
  logic [1:0]      code_q, code_d;
  logic            vld_q, vld_d;
  logic            pend_q, pend_d;
  logic            asleep_q, asleep_d;
  logic [CT_W-1:0] ct_q, ct_d;

  logic            hs;
  logic            pend_eff;
  logic [CT_W-1:0] ct_inc;

  always_comb begin
    hs       = vld_q & cmd.cmd_ready;
    // A key arriving on the very handshake edge still chains the wake.
    pend_eff = pend_q | (key_edge & (target_q != ST_ACTIVE));
    ct_inc   = (&ct_q) ? ct_q : ct_q + 1'b1;

    state_d  = state_q;
    target_d = target_q;
    code_d   = code_q;
    vld_d    = vld_q;
    pend_d   = pend_q;
    ct_d     = ct_q;

    case (state_q)
      ST_ACTIVE: begin
        ct_d = ct_inc;
        if (key_edge) begin
          ct_d = '0;
        end else if (force_sleep || ct_q >= SLEEP_CT) begin
          state_d = ST_CMD; target_d = ST_SLEEP; code_d = CODE_SLEEP; vld_d = 1'b1;
        end else if (ct_q >= DIM_CT) begin
          state_d = ST_CMD; target_d = ST_DIM; code_d = CODE_DIM; vld_d = 1'b1;
        end
      end
      ST_DIM: begin
        ct_d = ct_inc;
        if (key_edge) begin
          ct_d    = '0;
          state_d = ST_CMD; target_d = ST_ACTIVE; code_d = CODE_BRIGHT; vld_d = 1'b1;
        end else if (force_sleep || ct_q >= SLEEP_CT) begin
          state_d = ST_CMD; target_d = ST_SLEEP; code_d = CODE_SLEEP; vld_d = 1'b1;
        end
      end
      ST_SLEEP: begin
        ct_d = ct_inc;
        if (key_edge) begin
          ct_d    = '0;
          state_d = ST_CMD; target_d = ST_ACTIVE; code_d = CODE_WAKE; vld_d = 1'b1;
        end
      end
      default: begin
        // CMD: counter frozen; valid raised on entry from reset.
        vld_d = 1'b1;
        if (key_edge) begin
          ct_d = '0;
          if (target_q != ST_ACTIVE) pend_d = 1'b1;
        end
        if (hs) begin
          pend_d = 1'b0;
          if (pend_eff) begin
            target_d = ST_ACTIVE;
            code_d   = (target_q == ST_DIM) ? CODE_BRIGHT : CODE_WAKE;
          end else begin
            state_d = target_q;
            vld_d   = 1'b0;
            if (target_q == ST_ACTIVE) ct_d = '0;
          end
        end
      end
    endcase

    asleep_d = (state_d == ST_SLEEP);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= ST_CMD;
      target_q <= ST_ACTIVE;
      code_q   <= CODE_WAKE;
      vld_q    <= 1'b0;
      pend_q   <= 1'b0;
      asleep_q <= 1'b0;
      ct_q     <= '0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      code_q   <= code_d;
      vld_q    <= vld_d;
      pend_q   <= pend_d;
      asleep_q <= asleep_d;
      ct_q     <= ct_d;
    end
  end

  assign cmd.cmd_valid = vld_q;
  assign cmd.cmd_code  = code_q;
  assign state         = state_q;
  assign asleep        = asleep_q;
  assign idle_ct       = ct_q;

endmodule

// File: tb/tb_t04_screen_power_ctrl.sv
// Directed bench for the screen power controller; accepted commands are scored against a queue.
module tb_t04_screen_power_ctrl;
  localparam int CT_W = 5;

  logic            clk = 1'b0;
  logic            rst;
  logic            key_edge;
  logic            force_sleep;
  logic [1:0]      state;
  logic            asleep;
  logic [CT_W-1:0] idle_ct;

  t04_screen_power_ctrl_if ifc();

  t04_screen_power_ctrl #(
    .CT_W(CT_W), .DIM_CT(5'd10), .SLEEP_CT(5'd20)
  ) dut (
    .clk(clk), .rst(rst), .key_edge(key_edge), .force_sleep(force_sleep),
    .cmd(ifc.master), .state(state), .asleep(asleep), .idle_ct(idle_ct)
  );

  always #5 clk = ~clk;

  int         errors = 0;
  int         checks = 0;
  int         hs_count = 0;
  logic [1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock; any handshake on that edge pops the scoreboard.
  task automatic step();
    logic       hs;
    logic [1:0] code;
    hs   = ifc.cmd_valid && ifc.cmd_ready && rst;
    code = ifc.cmd_code;
    @(posedge clk);
    #1;
    if (hs) begin
      hs_count++;
      if (exp_q.size() == 0) check("sb_underflow", 32'(exp_q.size()), 1);
      else check("cmd_code_accepted", 32'(code), 32'(exp_q.pop_front()));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int hs_snap;
    rst = 1'b0; key_edge = 1'b0; force_sleep = 1'b0; ifc.cmd_ready = 1'b1;

    // 1. reset and boot
    repeat (3) step();
    check("rst_state", 32'(state), 3);
    check("rst_valid", 32'(ifc.cmd_valid), 0);
    check("rst_idle", 32'(idle_ct), 0);
    check("rst_asleep", 32'(asleep), 0);
    rst = 1'b1;
    exp_q.push_back(2'b00);
    step();
    check("boot_valid", 32'(ifc.cmd_valid), 1);
    check("boot_state", 32'(state), 3);
    step();
    check("boot_active", 32'(state), 0);
    check("boot_idle0", 32'(idle_ct), 0);
    step();
    check("boot_idle1", 32'(idle_ct), 1);
    step();
    check("boot_idle2", 32'(idle_ct), 2);

    // 2. timeout chain
    exp_q.push_back(2'b01);
    for (int i = 0; i < 40 && idle_ct != 5'd10; i++) step();
    check("dim_reach_idle", 32'(idle_ct), 10);
    check("dim_pre_state", 32'(state), 0);
    step();
    check("dim_cmd_state", 32'(state), 3);
    check("dim_cmd_valid", 32'(ifc.cmd_valid), 1);
    check("dim_cmd_code", 32'(ifc.cmd_code), 1);
    step();
    check("dim_state", 32'(state), 1);
    check("dim_idle_frozen", 32'(idle_ct), 11);
    exp_q.push_back(2'b10);
    for (int i = 0; i < 40 && idle_ct != 5'd20; i++) step();
    check("sleep_reach_idle", 32'(idle_ct), 20);
    step();
    check("sleep_cmd_state", 32'(state), 3);
    check("sleep_cmd_code", 32'(ifc.cmd_code), 2);
    step();
    check("sleep_state", 32'(state), 2);
    check("sleep_asleep", 32'(asleep), 1);
    repeat (12) step();
    check("sat_idle", 32'(idle_ct), 31);
    for (int i = 0; i < 10; i++) begin
      step();
      check("sat_hold", 32'(idle_ct), 31);
    end

    // 3. wake with backpressure
    ifc.cmd_ready = 1'b0;
    key_edge = 1'b1;
    exp_q.push_back(2'b00);
    step();
    key_edge = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("wake_bp_valid", 32'(ifc.cmd_valid), 1);
      check("wake_bp_code", 32'(ifc.cmd_code), 0);
      if (i < 4) step();
    end
    ifc.cmd_ready = 1'b1;
    step();
    check("wake_state", 32'(state), 0);
    check("wake_idle", 32'(idle_ct), 0);
    check("wake_asleep", 32'(asleep), 0);

    // 4. brighten and priority
    exp_q.push_back(2'b01);
    for (int i = 0; i < 40 && state != 2'd1; i++) step();
    check("dim2_state", 32'(state), 1);
    key_edge = 1'b1;
    exp_q.push_back(2'b11);
    step();
    key_edge = 1'b0;
    check("bright_code", 32'(ifc.cmd_code), 3);
    check("bright_cmd_state", 32'(state), 3);
    step();
    check("bright_state", 32'(state), 0);
    check("bright_idle", 32'(idle_ct), 0);
    step();
    step();
    hs_snap = hs_count;
    key_edge = 1'b1;
    force_sleep = 1'b1;
    step();
    key_edge = 1'b0;
    force_sleep = 1'b0;
    check("prio_state", 32'(state), 0);
    check("prio_idle", 32'(idle_ct), 0);
    check("prio_valid", 32'(ifc.cmd_valid), 0);
    step();
    check("prio_no_cmd", 32'(hs_count - hs_snap), 0);

    // 5. pending wake
    ifc.cmd_ready = 1'b0;
    force_sleep = 1'b1;
    exp_q.push_back(2'b10);
    exp_q.push_back(2'b00);
    step();
    force_sleep = 1'b0;
    check("pend_sleep_code", 32'(ifc.cmd_code), 2);
    key_edge = 1'b1;
    step();
    key_edge = 1'b0;
    check("pend_not_sleep_a", 32'(state == 2'd2), 0);
    step();
    ifc.cmd_ready = 1'b1;
    step();
    check("pend_chain_state", 32'(state), 3);
    check("pend_chain_valid", 32'(ifc.cmd_valid), 1);
    check("pend_chain_code", 32'(ifc.cmd_code), 0);
    step();
    check("pend_final_state", 32'(state), 0);

    // 6. reset mid-command
    ifc.cmd_ready = 1'b0;
    force_sleep = 1'b1;
    step();
    force_sleep = 1'b0;
    key_edge = 1'b1;
    step();
    key_edge = 1'b0;
    check("mid_valid_pre", 32'(ifc.cmd_valid), 1);
    rst = 1'b0;
    step();
    check("mid_rst_valid", 32'(ifc.cmd_valid), 0);
    check("mid_rst_state", 32'(state), 3);
    check("mid_rst_idle", 32'(idle_ct), 0);
    rst = 1'b1;
    exp_q.push_back(2'b00);
    step();
    check("rewake_valid", 32'(ifc.cmd_valid), 1);
    check("rewake_code", 32'(ifc.cmd_code), 0);
    ifc.cmd_ready = 1'b1;
    step();
    check("rewake_state", 32'(state), 0);
    check("sb_drained", 32'(exp_q.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
